hist_access_arbiter: RTL
========================

Name: hist_access_arbiter

Overview:
- Shares the single bin-update port of the 64-bin histogram core between NUM_REQ independent event sources.
- Round-robin arbitration; sequences every write through an issue/settle pair so the core's one-cycle-late ready is honoured.
- Owns host-requested flushes (forced dump + bin clear) and watches each dump for completion or timeout.
- Sits between the event front-ends and the histogram core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BIN_W, 6, bin index width (64 bins).
- DUMP_TIMEOUT, 96, max cycles in DUMP_WAIT before the error is flagged; must exceed bin count + 2.
- CNT_W, 16, width of the accepted-event counter.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester event pending.
- req_bin  in  NUM_REQ*BIN_W  bin index of requester i at [i*BIN_W +: BIN_W].
- req_ready  out  NUM_REQ  one-hot combinational accept; the event transfers when req_valid[i] & req_ready[i].
- flush_req  in  1  level request to dump and clear the histogram.
- flush_done  out  1  one-cycle pulse when a flush completes.
- hist_wr_en  out  1  registered write strobe to the core.
- hist_bin  out  BIN_W  registered bin index, valid while hist_wr_en is high.
- hist_flush  out  1  registered one-cycle forced-dump pulse to the core.
- hist_ready  in  1  core can accept a write (low while dumping).
- hist_last  in  1  core's last-bin marker of a dump.
- err_timeout  out  1  sticky; cleared only by reset.
- evt_count  out  CNT_W  accepted events; saturates at all-ones.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. Reset values:
  - state = ARB, rr_ptr = 0.
  - hist_wr_en = hist_flush = flush_done = err_timeout = 0.
  - hist_bin = 0, evt_count = 0.
  - req_ready = 0 while rst_n is low.
- State ARB:
  - If flush_req = 1 and hist_ready = 1: no grant, hist_flush <= 1, go to DUMP_WAIT. A flush beats all requesters.
  - Else if hist_ready = 1 and any req_valid is set: the winner is the first set bit scanning from rr_ptr upward, modulo NUM_REQ. req_ready[winner] = 1 in this cycle. hist_bin <= req_bin[winner], hist_wr_en <= 1, rr_ptr <= (winner+1) mod NUM_REQ, evt_count += 1 (saturating). Go to ISSUE.
  - Else stay in ARB, with req_ready = 0.
- Latency: accept in cycle N gives hist_wr_en high for exactly cycle N+1.
- State ISSUE: hist_wr_en <= 0, no grants, go to SETTLE.
- State SETTLE: sample hist_ready, which now reflects the write.
  - If 1: go to ARB.
  - If 0 (saturating write triggered a dump): go to DUMP_WAIT, with no flush_done attributed.
- Throughput: at most one write per 3 cycles.
- State DUMP_WAIT:
  - Grants are blocked; a wait counter increments every cycle.
  - On hist_last = 1: go to DRAIN. If this dump was caused by a flush, flush_done pulses the cycle after hist_last.
  - If the counter reaches DUMP_TIMEOUT: set err_timeout, go to ARB, pulse flush_done if a flush was pending.
- State DRAIN: wait until hist_ready = 1 (bin clear has finished), then go to ARB.
- hist_flush is high for exactly one cycle per flush.
- flush_req still high on return to ARB: a new flush starts. The requester must drop flush_req on flush_done.
- req_valid dropping while not granted is legal; nothing is consumed.
- Reset mid-dump: everything returns to reset values immediately. No flush_done is emitted and no partial state is retained.
- NUM_REQ = 1 degenerates to pass-through with the 3-cycle cadence.

Decomposition:
- Shared package hist_pkg holds:
  - the state enum (ARB, ISSUE, SETTLE, DUMP_WAIT, DRAIN);
  - BIN_W, NUM_BINS = 64 and the default DUMP_TIMEOUT.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are the request vector and pointer; outputs are a one-hot grant and the winner index. The core itself stays separate.

Test Plan:
- Reset: hold rst_n = 0 with all req_valid = 1 -> all outputs 0 and req_ready = 0. After release, the first grant goes to requester 0.
- Fairness: NUM_REQ = 4, all valid continuously, bins 1/2/3/4 -> hist_bin sequence 1,2,3,4,1 with hist_wr_en every 3rd cycle. evt_count = 5 after 5 grants.
- Saturation dump: 15 writes to bin 5 from req 2, then hist_ready falls after the 15th write -> state is DUMP_WAIT in the cycle after SETTLE.
  - No grants until hist_last arrives and hist_ready = 1.
  - flush_done stays 0 throughout.
- Flush priority: flush_req = 1 together with req_valid = 4'b1111 in ARB -> hist_flush pulses once and req_ready stays 0.
  - hist_last at cycle T gives flush_done = 1 at T+1.
- Timeout: hold hist_last = 0 after a flush -> err_timeout = 1 after 96 cycles. It stays set through later traffic and is cleared only by rst_n.
- Async reset mid-DUMP_WAIT: pulse rst_n low for a non-edge-aligned half cycle -> outputs clear immediately, with no flush_done.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram access arbiter.
package hist_pkg;

    localparam int BIN_W        = 6;
    localparam int NUM_BINS     = 64;
    localparam int DUMP_TIMEOUT = 96;

    typedef enum logic [2:0] {
        ARB,
        ISSUE,
        SETTLE,
        DUMP_WAIT,
        DRAIN
    } arb_state_e;

endpackage

// File: rtl/hist_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/hist_access_arbiter.sv
// Shares the histogram core's single bin-update port between NUM_REQ sources,
// sequences each write as issue/settle and owns host flushes and dump watching.
module hist_access_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BIN_W        = hist_pkg::BIN_W,
    parameter int DUMP_TIMEOUT = hist_pkg::DUMP_TIMEOUT,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*BIN_W-1:0] req_bin_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     flush_req_i,
    output logic                     flush_done_o,
    output logic                     hist_wr_en_o,
    output logic [BIN_W-1:0]         hist_bin_o,
    output logic                     hist_flush_o,
    input  logic                     hist_ready_i,
    input  logic                     hist_last_i,
    output logic                     err_timeout_o,
    output logic [CNT_W-1:0]         evt_count_o
);
    import hist_pkg::*;

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WAIT_W = $clog2(DUMP_TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               wr_en_q, wr_en_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               flush_q, flush_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               pend_q, pend_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] grant_c;

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        wr_en_d  = 1'b0;
        bin_d    = bin_q;
        flush_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        pend_d   = pend_q;
        grant_c  = '0;
        case (state_q)
            ARB: begin
                if (flush_req_i && hist_ready_i) begin
                    flush_d = 1'b1;
                    pend_d  = 1'b1;
                    wait_d  = '0;
                    state_d = DUMP_WAIT;
                end else if (hist_ready_i && pick_any) begin
                    grant_c  = pick_gnt;
                    bin_d    = req_bin_i[int'(pick_idx)*BIN_W +: BIN_W];
                    wr_en_d  = 1'b1;
                    rr_ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
                    if (cnt_q != '1)
                        cnt_d = cnt_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = SETTLE;
            SETTLE: begin
                // ready has had a cycle to reflect the write; low means the core started a dump
                if (hist_ready_i) begin
                    state_d = ARB;
                end else begin
                    wait_d  = '0;
                    pend_d  = 1'b0;
                    state_d = DUMP_WAIT;
                end
            end
            DUMP_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (hist_last_i) begin
                    done_d  = pend_q;
                    pend_d  = 1'b0;
                    state_d = DRAIN;
                end else if (wait_q == WAIT_W'(DUMP_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    done_d  = pend_q;
                    pend_d  = 1'b0;
                    state_d = ARB;
                end
            end
            DRAIN: begin
                if (hist_ready_i)
                    state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            wr_en_q  <= 1'b0;
            bin_q    <= '0;
            flush_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            wait_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= wr_en_d;
            bin_q    <= bin_d;
            flush_q  <= flush_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            pend_q   <= pend_d;
        end
    end

    // state_q already reads ARB during reset, so the grant is masked explicitly
    assign req_ready_o   = grant_c & {NUM_REQ{rst_n}};
    assign hist_wr_en_o  = wr_en_q;
    assign hist_bin_o    = bin_q;
    assign hist_flush_o  = flush_q;
    assign flush_done_o  = done_q;
    assign err_timeout_o = err_q;
    assign evt_count_o   = cnt_q;

endmodule
